div_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU). The decoder issues these with register write disabled and a jump target of the next instruction; the execute stage pulses `start_i` here. The controller then holds the pipeline via `busy_o`, runs a 32-step restoring division and returns the result with its own write-back strobe. It sits beside ex and feeds the pipeline hold/flush controller.

---
 rtl/div_ctrl_pkg.sv | 29 ++
 rtl/div_ctrl_step.sv | 25 ++
 rtl/div_ctrl.sv | 148 ++++++++++++++
 tb/tb_div_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the RV32M divide sequencer: state encodings,
// funct3 opcodes, reset/write-enable constants and opcode helpers.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_START = 2'd1,
    DIV_CALC  = 2'd2,
    DIV_END   = 2'd3
  } div_state_e;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic RST_ENABLE    = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_REM);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return (op == INST_REM) || (op == INST_REMU);
  endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // rem < divisor holds on entry, so a taken subtraction always fits XLEN bits
  always_comb begin
    shifted   = {rem, quot[XLEN-1]};
    ge        = shifted >= {1'b0, divisor};
    diff      = shifted[XLEN-1:0] - divisor;
    rem_next  = ge ? diff : shifted[XLEN-1:0];
    quot_next = {quot[XLEN-2:0], ge};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer (restoring, one bit per cycle).
// Optional: define DIV_EARLY_OUT_EN to finish zero-divisor operations in 2 edges.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            cancel_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);

  div_state_e      state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] dividend_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic [5:0]      cnt_q;
  logic            neg_q;
  logic            neg_r;
  logic [4:0]      waddr_q;
  logic            done_q;
  logic [4:0]      reg_waddr_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] rem_step, quot_step;
  logic [XLEN-1:0] dividend_abs, divisor_abs;
  logic [XLEN-1:0] quot_fix, rem_fix;
  logic            sgn_op;

  div_step #(.XLEN(XLEN)) u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (divisor_q),
    .rem_next  (rem_step),
    .quot_next (quot_step)
  );

  always_comb begin
    sgn_op       = op_is_signed(op_q);
    dividend_abs = (sgn_op && dividend_q[XLEN-1]) ? -dividend_q : dividend_q;
    divisor_abs  = (sgn_op && divisor_q[XLEN-1])  ? -divisor_q  : divisor_q;
    quot_fix     = neg_q ? -quot_q : quot_q;
    rem_fix      = neg_r ? -rem_q  : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= DIV_IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE:  if (start_i && !cancel_i) state_d = DIV_START;
      DIV_START: begin
        if (cancel_i) state_d = DIV_IDLE;
`ifdef DIV_EARLY_OUT_EN
        else if (divisor_q == '0) state_d = DIV_END;
`endif
        else state_d = DIV_CALC;
      end
      DIV_CALC: begin
        if (cancel_i)                state_d = DIV_IDLE;
        else if (cnt_q == LAST_STEP) state_d = DIV_END;
      end
      DIV_END:   state_d = DIV_IDLE;
      default:   state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      op_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      waddr_q     <= '0;
      done_q      <= WRITE_DISABLE;
      reg_waddr_q <= '0;
      result_q    <= '0;
    end else begin
      done_q <= WRITE_DISABLE;
      case (state_q)
        DIV_IDLE: begin
          if (start_i && !cancel_i) begin
            op_q       <= op_i;
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            waddr_q    <= reg_waddr_i;
          end
        end
        DIV_START: begin
          divisor_q <= divisor_abs;
          quot_q    <= dividend_abs;
          rem_q     <= '0;
          neg_q     <= sgn_op && (dividend_q[XLEN-1] ^ divisor_q[XLEN-1]) && (divisor_q != '0);
          neg_r     <= sgn_op && dividend_q[XLEN-1];
          cnt_q     <= '0;
`ifdef DIV_EARLY_OUT_EN
          // Preload what 32 steps against a zero divisor would produce
          if (divisor_q == '0) begin
            quot_q <= '1;
            rem_q  <= dividend_abs;
          end
`endif
        end
        DIV_CALC: begin
          rem_q  <= rem_step;
          quot_q <= quot_step;
          cnt_q  <= cnt_q + 6'd1;
        end
        DIV_END: begin
          if (!cancel_i) begin
            done_q      <= WRITE_ENABLE;
            result_q    <= op_is_rem(op_q) ? rem_fix : quot_fix;
            reg_waddr_q <= waddr_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q != DIV_IDLE);
  assign done_o      = done_q;
  assign reg_we_o    = done_q;
  assign reg_waddr_o = reg_waddr_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases with literal expectations
// plus randomized traffic checked each cycle against an arithmetic reference.
module tb_div_ctrl;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;
  localparam int LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = OP_DIVU;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd = '0;
  logic        busy_o, done_o, reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = '0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] p_res = '0;
  logic [4:0]  p_rd = '0;

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .cancel_i    (cancel),
    .op_i        (op),
    .dividend_i  (a),
    .divisor_i   (b),
    .reg_waddr_i (rd),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .result_o    (result_o)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      OP_DIV:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(x) / $signed(y));
      OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REM:  return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the reference on the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_left = 0; m_done = 1'b0; m_result = '0; m_waddr = '0;
    end else begin
      m_done = 1'b0;
      if (m_left != 0) begin
        if (cancel) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1; m_result = p_res; m_waddr = p_rd;
          end
        end
      end else if (start && !cancel) begin
        p_res  = ref_res(op, a, b);
        p_rd   = rd;
        m_left = (b == 0) ? ZLAT : LAT;
      end
    end
    @(negedge clk);
    chk("busy", 32'(busy_o), 32'(m_left != 0));
    chk("done", 32'(done_o), 32'(m_done));
    chk("reg_we", 32'(reg_we_o), 32'(m_done));
    chk("result", result_o, m_result);
    chk("waddr", 32'(reg_waddr_o), 32'(m_waddr));
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] r, input logic [31:0] exp_res, input logic [4:0] exp_rd,
                     input int exp_lat, input int inj_k, input int can_k, input int rst_k);
    int busy_cnt, lat;
    bit seen;
    op = o; a = x; b = y; rd = r; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = busy_o ? 1 : 0;
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == inj_k) begin start = 1'b1; op = OP_DIVU; a = 32'd7; b = 32'd1; rd = 5'd31; end
      if (k == can_k) cancel = 1'b1;
      if (k == rst_k) rst = 1'b0;
      tick();
      start = 1'b0; cancel = 1'b0; rst = 1'b1;
      if (done_o && !seen) begin seen = 1'b1; lat = k; end
      if (busy_o) busy_cnt++;
      if (exp_lat > 0 && seen) break;
    end
    if (exp_lat > 0) begin
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
    end else begin
      chk("no_done", 32'(seen), 32'd0);
    end
    chk("lit_result", result_o, exp_res);
    chk("lit_waddr", 32'(reg_waddr_o), 32'(exp_rd));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("reset_result", result_o, 32'h0);

    run(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 5'd5, LAT, -1, -1, -1);
    run(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, 5'd1, LAT, -1, -1, -1);
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, 5'd2, LAT, -1, -1, -1);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 5'd3, LAT, -1, -1, -1);
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h0, 5'd4, LAT, -1, -1, -1);
    run(OP_DIV, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 5'd6, ZLAT, -1, -1, -1);
    run(OP_REMU, 32'd5, 32'd0, 5'd7, 32'd5, 5'd7, ZLAT, -1, -1, -1);
    run(OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd8, 32'hFFFF_FFFF, 5'd8, ZLAT, -1, -1, -1);
    run(OP_DIVU, 32'd1000, 32'd10, 5'd9, 32'd100, 5'd9, LAT, 10, -1, -1);
    run(OP_DIV, 32'd50, 32'd5, 5'd10, 32'd100, 5'd9, 0, -1, 13, -1);
    run(OP_DIVU, 32'd77, 32'd7, 5'd11, 32'h0, 5'd0, 0, -1, -1, 20);
    run(OP_REMU, 32'd78, 32'd7, 5'd12, 32'd1, 5'd12, LAT, -1, -1, -1);

    // simultaneous start and cancel in idle must not launch anything
    op = OP_DIVU; a = 32'd9; b = 32'd3; rd = 5'd13; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_idle", 32'(busy_o), 32'd0);

    for (int n = 0; n < 40; n++) begin
      int guard;
      op = 3'b100 | 3'($urandom_range(0, 3));
      a = pick(); b = pick(); rd = 5'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      guard = 0;
      while (m_left != 0 && guard < 60) begin
        cancel = ($urandom_range(0, 99) == 0);
        start  = ($urandom_range(0, 9) == 0);
        a = $urandom; b = $urandom; op = 3'b100 | 3'($urandom_range(0, 3));
        tick();
        cancel = 1'b0; start = 1'b0;
        guard++;
      end
      if (m_left != 0) chk("op_timeout", 32'(m_left), 32'd0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
